// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor
// Purpose  : N-channel pipelined sprite compositor: box test, ROM addressing,
//            colour key, fixed priority, hit-flash blink, frame collisions.
// Revision : 1.0
// ============================================================================
module sprite_compositor #(
    parameter int          NUM_SPR      = 4,
    parameter int          SPR_W_LOG2   = 5,
    parameter int          SPR_H_LOG2   = 5,
    parameter int          ADDR_W       = 19,
    parameter int          ROM_LAT      = 1,
    parameter logic [23:0] KEY_COLOR    = 24'hFF0000,
    parameter logic [23:0] BG_COLOR     = 24'hB7FE7B,
    parameter int          FLASH_FRAMES = 6
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_start,
    input  logic                      pix_valid,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [NUM_SPR*10-1:0]     spr_x,
    input  logic [NUM_SPR*10-1:0]     spr_y,
    input  logic [NUM_SPR-1:0]        spr_en,
    input  logic [NUM_SPR-1:0]        flash_req,
    output logic [NUM_SPR*ADDR_W-1:0] rom_addr,
    input  logic [NUM_SPR*24-1:0]     rom_data,
    output logic [7:0]                VGA_R,
    output logic [7:0]                VGA_G,
    output logic [7:0]                VGA_B,
    output logic                      pix_valid_out,
    output logic [NUM_SPR-1:0]        collide,
    output logic                      collide_valid
);

    localparam int                 c_cnt_w      = $clog2(FLASH_FRAMES + 1);
    localparam logic [10:0]        c_spr_w      = 11'(1 << SPR_W_LOG2);
    localparam logic [10:0]        c_spr_h      = 11'(1 << SPR_H_LOG2);
    localparam logic [c_cnt_w-1:0] c_flash_load = c_cnt_w'(FLASH_FRAMES);

    // Stage A registers
    logic [NUM_SPR*ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [NUM_SPR-1:0]        hit_a_q, hit_a_d;
    logic                      valid_a_q, valid_a_d;

    // ROM-latency alignment
    logic [NUM_SPR-1:0]        hit_dly_q [ROM_LAT];
    logic [NUM_SPR-1:0]        hit_dly_d [ROM_LAT];
    logic [ROM_LAT-1:0]        valid_dly_q, valid_dly_d;

    // Stage B / frame state
    logic [c_cnt_w-1:0]        flash_cnt_q [NUM_SPR];
    logic [c_cnt_w-1:0]        flash_cnt_d [NUM_SPR];
    logic [23:0]               rgb_q, rgb_d;
    logic                      pix_valid_out_q, pix_valid_out_d;
    logic [NUM_SPR-1:0]        acc_q, acc_d;
    logic [NUM_SPR-1:0]        collide_q, collide_d;
    logic                      collide_valid_q, collide_valid_d;

    logic [10:0]               w_px, w_py;
    logic [NUM_SPR-1:0]        w_hit_a, w_hit_b, w_hidden, w_opaque, w_contrib;
    logic [NUM_SPR*ADDR_W-1:0] w_addr_a;
    logic                      w_valid_b;
    logic [23:0]               w_sel;

    // 11-bit coordinates keep the box end from wrapping past 1023
    assign w_px      = {1'b0, DrawX};
    assign w_py      = {1'b0, DrawY};
    assign w_hit_b   = hit_dly_q[ROM_LAT-1];
    assign w_valid_b = valid_dly_q[ROM_LAT-1];

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_chan
        logic [10:0] w_sx, w_sy, w_dx, w_dy;
        logic [23:0] w_pix;

        assign w_sx = {1'b0, spr_x[10*i +: 10]};
        assign w_sy = {1'b0, spr_y[10*i +: 10]};
        assign w_dx = w_px - w_sx;
        assign w_dy = w_py - w_sy;

        assign w_hit_a[i] = spr_en[i] & pix_valid
                          & (w_px >= w_sx) & (w_px < w_sx + c_spr_w)
                          & (w_py >= w_sy) & (w_py < w_sy + c_spr_h);

        assign w_addr_a[ADDR_W*i +: ADDR_W] = w_hit_a[i]
            ? (ADDR_W'(w_dx) + (ADDR_W'(w_dy) << SPR_W_LOG2)) : '0;

        assign w_pix       = rom_data[24*i +: 24];
        assign w_hidden[i] = (flash_cnt_q[i] != '0) & flash_cnt_q[i][0];
        assign w_opaque[i] = w_hit_b[i] & (w_pix != KEY_COLOR) & ~w_hidden[i];
    end

    always_comb begin
        rom_addr_d = w_addr_a;
        hit_a_d    = w_hit_a;
        valid_a_d  = pix_valid;

        hit_dly_d[0]   = hit_a_q;
        valid_dly_d[0] = valid_a_q;
        for (int k = 1; k < ROM_LAT; k++) begin
            hit_dly_d[k]   = hit_dly_q[k-1];
            valid_dly_d[k] = valid_dly_q[k-1];
        end

        // Walk from lowest priority upward so channel 0 has the final say
        w_sel = BG_COLOR;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_sel = rom_data[24*i +: 24];
            end
        end
        rgb_d           = w_valid_b ? w_sel : 24'h000000;
        pix_valid_out_d = w_valid_b;

        // Two or more opaque bits set means clearing the lowest one leaves a remainder
        w_contrib = ((w_opaque & (w_opaque - NUM_SPR'(1))) != '0) ? w_opaque : '0;

        if (frame_start) begin
            collide_d       = acc_q | w_contrib;
            acc_d           = '0;
            collide_valid_d = 1'b1;
        end else begin
            collide_d       = collide_q;
            acc_d           = acc_q | w_contrib;
            collide_valid_d = 1'b0;
        end

        for (int i = 0; i < NUM_SPR; i++) begin
            flash_cnt_d[i] = flash_cnt_q[i];
            if (flash_req[i]) begin
                flash_cnt_d[i] = c_flash_load;
            end else if (frame_start && (flash_cnt_q[i] != '0)) begin
                flash_cnt_d[i] = flash_cnt_q[i] - c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q      <= '0;
            hit_a_q         <= '0;
            valid_a_q       <= 1'b0;
            valid_dly_q     <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                hit_dly_q[k] <= '0;
            end
            for (int i = 0; i < NUM_SPR; i++) begin
                flash_cnt_q[i] <= '0;
            end
            rgb_q           <= '0;
            pix_valid_out_q <= 1'b0;
            acc_q           <= '0;
            collide_q       <= '0;
            collide_valid_q <= 1'b0;
        end else begin
            rom_addr_q      <= rom_addr_d;
            hit_a_q         <= hit_a_d;
            valid_a_q       <= valid_a_d;
            valid_dly_q     <= valid_dly_d;
            for (int k = 0; k < ROM_LAT; k++) begin
                hit_dly_q[k] <= hit_dly_d[k];
            end
            for (int i = 0; i < NUM_SPR; i++) begin
                flash_cnt_q[i] <= flash_cnt_d[i];
            end
            rgb_q           <= rgb_d;
            pix_valid_out_q <= pix_valid_out_d;
            acc_q           <= acc_d;
            collide_q       <= collide_d;
            collide_valid_q <= collide_valid_d;
        end
    end

    assign rom_addr      = rom_addr_q;
    assign VGA_R         = rgb_q[23:16];
    assign VGA_G         = rgb_q[15:8];
    assign VGA_B         = rgb_q[7:0];
    assign pix_valid_out = pix_valid_out_q;
    assign collide       = collide_q;
    assign collide_valid = collide_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_compositor
// Purpose  : Self-checking bench for sprite_compositor with a ROM model and a
//            behavioural frame/pixel reference model.
// Revision : 1.0
// ============================================================================
module tb_sprite_compositor;

    localparam int          NUM_SPR      = 4;
    localparam int          SPR_W_LOG2   = 5;
    localparam int          SPR_H_LOG2   = 5;
    localparam int          ADDR_W       = 19;
    localparam int          ROM_LAT      = 1;
    localparam int          FLASH_FRAMES = 6;
    localparam logic [23:0] KEY          = 24'hFF0000;
    localparam logic [23:0] BG           = 24'hB7FE7B;
    localparam int          LAT          = ROM_LAT + 2;

    logic                      Clk         = 1'b0;
    logic                      Reset_n     = 1'b1;
    logic                      frame_start = 1'b0;
    logic                      pix_valid   = 1'b0;
    logic [9:0]                DrawX       = '0;
    logic [9:0]                DrawY       = '0;
    logic [NUM_SPR*10-1:0]     spr_x       = '0;
    logic [NUM_SPR*10-1:0]     spr_y       = '0;
    logic [NUM_SPR-1:0]        spr_en      = '0;
    logic [NUM_SPR-1:0]        flash_req   = '0;
    logic [NUM_SPR*ADDR_W-1:0] rom_addr;
    logic [NUM_SPR*24-1:0]     rom_data;
    logic [7:0]                VGA_R, VGA_G, VGA_B;
    logic                      pix_valid_out;
    logic [NUM_SPR-1:0]        collide;
    logic                      collide_valid;

    logic [NUM_SPR-1:0]        ovr_en  = '0;
    logic [NUM_SPR*24-1:0]     ovr_val = '0;

    int errs   = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    sprite_compositor #(
        .NUM_SPR(NUM_SPR), .SPR_W_LOG2(SPR_W_LOG2), .SPR_H_LOG2(SPR_H_LOG2),
        .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT), .KEY_COLOR(KEY), .BG_COLOR(BG),
        .FLASH_FRAMES(FLASH_FRAMES)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .flash_req(flash_req),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .pix_valid_out(pix_valid_out), .collide(collide),
        .collide_valid(collide_valid)
    );

    // Sprite ROM contents: an override colour per channel, otherwise a pattern
    // in which every address ending in 3'b101 is transparent.
    function automatic logic [23:0] rom_f(input int ch, input logic [ADDR_W-1:0] a,
                                          input logic [NUM_SPR-1:0] oe,
                                          input logic [NUM_SPR*24-1:0] ov);
        if (oe[ch]) return ov[24*ch +: 24];
        if (a[2:0] == 3'd5) return KEY;
        return {8'(ch * 50 + 1), a[7:0], a[15:8] ^ 8'h3C};
    endfunction

    logic [NUM_SPR*ADDR_W-1:0] apipe [ROM_LAT];
    always @(posedge Clk) begin
        apipe[0] <= rom_addr;
        for (int k = 1; k < ROM_LAT; k++) apipe[k] <= apipe[k-1];
    end
    always_comb begin
        rom_data = '0;
        for (int ch = 0; ch < NUM_SPR; ch++)
            rom_data[24*ch +: 24] = rom_f(ch, apipe[ROM_LAT-1][ADDR_W*ch +: ADDR_W], ovr_en, ovr_val);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of per-pixel box results that reaches the
    // compositing point ROM_LAT+1 cycles after the pixel was presented.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic                      v;
        logic [NUM_SPR-1:0]        hit;
        logic [NUM_SPR*ADDR_W-1:0] addr;
    } rec_t;

    rec_t                      mq[$];
    int                        mcnt [NUM_SPR];
    logic [NUM_SPR-1:0]        macc     = '0;
    logic [23:0]               exp_rgb  = '0;
    logic                      exp_pv   = 1'b0;
    logic [NUM_SPR-1:0]        exp_col  = '0;
    logic                      exp_cv   = 1'b0;
    logic [NUM_SPR*ADDR_W-1:0] exp_addr = '0;

    always @(posedge Clk) begin
        rec_t               nr, r;
        logic [NUM_SPR-1:0] opq, contrib;
        logic [23:0]        c;
        bit                 found;
        int                 dx, dy;
        if (!Reset_n) begin
            mq.delete();
            for (int k = 0; k < ROM_LAT + 1; k++) mq.push_back('0);
            for (int i = 0; i < NUM_SPR; i++) mcnt[i] = 0;
            macc = '0; exp_rgb = '0; exp_pv = 0; exp_col = '0; exp_cv = 0; exp_addr = '0;
        end else begin
            nr   = '0;
            nr.v = pix_valid;
            for (int i = 0; i < NUM_SPR; i++) begin
                dx = int'(DrawX) - int'(spr_x[10*i +: 10]);
                dy = int'(DrawY) - int'(spr_y[10*i +: 10]);
                if (spr_en[i] && pix_valid && dx >= 0 && dx < (1 << SPR_W_LOG2)
                    && dy >= 0 && dy < (1 << SPR_H_LOG2)) begin
                    nr.hit[i] = 1'b1;
                    nr.addr[ADDR_W*i +: ADDR_W] = ADDR_W'(dx + dy * (1 << SPR_W_LOG2));
                end
            end
            mq.push_back(nr);
            r = mq.pop_front();

            opq = '0;
            for (int i = 0; i < NUM_SPR; i++)
                if (r.hit[i] && (mcnt[i] % 2 == 0)
                    && rom_f(i, r.addr[ADDR_W*i +: ADDR_W], ovr_en, ovr_val) != KEY)
                    opq[i] = 1'b1;
            c = BG; found = 0;
            for (int i = 0; i < NUM_SPR; i++)
                if (!found && opq[i]) begin
                    c = rom_f(i, r.addr[ADDR_W*i +: ADDR_W], ovr_en, ovr_val);
                    found = 1;
                end
            exp_rgb = r.v ? c : 24'h0;
            exp_pv  = r.v;

            contrib = ($countones(opq) >= 2) ? opq : '0;
            if (frame_start) begin
                exp_col = macc | contrib; macc = '0; exp_cv = 1'b1;
            end else begin
                macc = macc | contrib; exp_cv = 1'b0;
            end
            for (int i = 0; i < NUM_SPR; i++) begin
                if (flash_req[i]) mcnt[i] = FLASH_FRAMES;
                else if (frame_start && mcnt[i] > 0) mcnt[i] = mcnt[i] - 1;
            end
            exp_addr = nr.addr;
        end
    end

    always @(negedge Clk) begin
        if (!Reset_n) begin
            chk("reset_rgb", {VGA_R, VGA_G, VGA_B}, 0);
            chk("reset_pv", pix_valid_out, 0);
            chk("reset_collide", collide, 0);
            chk("reset_cv", collide_valid, 0);
            chk("reset_addr", rom_addr, 0);
        end else begin
            chk("rgb", {VGA_R, VGA_G, VGA_B}, exp_rgb);
            chk("pix_valid_out", pix_valid_out, exp_pv);
            chk("collide", collide, exp_col);
            chk("collide_valid", collide_valid, exp_cv);
            chk("rom_addr", rom_addr, exp_addr);
        end
    end

    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one pixel, optionally pin one channel's address, then pin the colour.
    task automatic pix_check(input string nm, input int x, input int y,
                             input logic [23:0] expc, input int ach, input int aexp);
        DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        @(negedge Clk);
        if (ach >= 0) chk({nm, "_addr"}, rom_addr[ADDR_W*ach +: ADDR_W], aexp);
        repeat (LAT - 1) @(negedge Clk);
        chk(nm, {VGA_R, VGA_G, VGA_B}, expc);
        tick();
    endtask

    task automatic frame_pulse(input string nm, input logic [NUM_SPR-1:0] expcol, input bit do_col);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge Clk);
        chk({nm, "_cv_hi"}, collide_valid, 1);
        if (do_col) chk(nm, collide, expcol);
        tick();
        @(negedge Clk);
        chk({nm, "_cv_lo"}, collide_valid, 0);
        tick();
    endtask

    initial begin
        #1 Reset_n = 1'b0;
        pix_valid = 1'b1; DrawX = 10'd10; DrawY = 10'd10;
        repeat (3) tick();
        @(negedge Clk);
        chk("rst_hold_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        chk("rst_hold_addr", rom_addr, 0);
        chk("rst_hold_collide", collide, 0);
        tick();
        Reset_n = 1'b1;
        repeat (LAT) @(negedge Clk);
        chk("first_out_early", pix_valid_out, 0);
        @(negedge Clk);
        chk("first_out_valid", pix_valid_out, 1);
        chk("first_out_bg", {VGA_R, VGA_G, VGA_B}, BG);
        tick();
        pix_valid = 1'b0;
        repeat (LAT + 1) tick();

        // Single sprite address and colour key
        spr_x[9:0] = 10'd100; spr_y[9:0] = 10'd50; spr_en = 4'b0001;
        ovr_en = 4'b0001; ovr_val[23:0] = 24'h123456;
        pix_check("sp0_color", 103, 52, 24'h123456, 0, 67);
        ovr_val[23:0] = KEY;
        pix_check("sp0_key_bg", 103, 52, BG, 0, 67);

        // Priority and collision between sprites 0 and 2
        spr_x = {10'd0, 10'd200, 10'd0, 10'd200};
        spr_y = {10'd0, 10'd200, 10'd0, 10'd200};
        spr_en = 4'b0101; ovr_en = 4'b0101;
        ovr_val = {24'h0, 24'h0D0E0F, 24'h0, 24'h0A0B0C};
        frame_pulse("clr", '0, 0);
        for (int k = 0; k < 4; k++)
            pix_check($sformatf("overlap_pri%0d", k), 200 + k, 200 + k, 24'h0A0B0C, 2, 33 * k);
        frame_pulse("collide_pair", 4'b0101, 1);
        spr_x[29:20] = 10'd400; spr_y[29:20] = 10'd400;
        pix_check("no_overlap", 201, 201, 24'h0A0B0C, 2, 0);
        frame_pulse("collide_clear", 4'b0000, 1);

        // Right-edge box test without 10-bit wrap
        spr_en = 4'b0010; spr_x[19:10] = 10'd1000; spr_y[19:10] = 10'd0;
        ovr_en = 4'b0010; ovr_val[47:24] = 24'h445566;
        pix_check("x1000_hit", 1010, 0, 24'h445566, 1, 10);
        spr_x[19:10] = 10'd1020;
        pix_check("x1020_nowrap", 3, 0, BG, 1, 0);

        // Disabled sprite overlapping an enabled one
        spr_x = {10'd0, 10'd0, 10'd250, 10'd250};
        spr_y = {10'd0, 10'd0, 10'd250, 10'd250};
        spr_en = 4'b0010; ovr_en = 4'b0011;
        ovr_val[23:0] = 24'hAABBCC; ovr_val[47:24] = 24'h445566;
        frame_pulse("clr2", '0, 0);
        pix_check("disabled_not_drawn", 252, 252, 24'h445566, 0, 0);
        frame_pulse("disabled_nocollide", 4'b0000, 1);

        // Hit flash: counts 6..0 with the sprite hidden on odd counts
        spr_x[9:0] = 10'd300; spr_y[9:0] = 10'd300; spr_en = 4'b0001;
        ovr_en = 4'b0001; ovr_val[23:0] = 24'h112233;
        flash_req = 4'b0001; tick(); flash_req = '0;
        for (int k = 0; k < 8; k++) begin
            pix_check($sformatf("flash_frame%0d", k), 305, 305,
                      (k == 1 || k == 3 || k == 5) ? BG : 24'h112233, 0, 165);
            frame_pulse("flash_fs", '0, 0);
        end
        flash_req = 4'b0001; frame_start = 1'b1; tick();
        flash_req = '0; frame_start = 1'b0;
        pix_check("flash_coincident_load", 305, 305, 24'h112233, 0, 165);
        frame_pulse("flash_fs2", '0, 0);
        pix_check("flash_after_coincident", 305, 305, BG, 0, 165);
        repeat (5) frame_pulse("flash_fs3", '0, 0);

        // Randomized traffic checked cycle by cycle against the model
        ovr_en = '0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                for (int i = 0; i < NUM_SPR; i++) begin
                    if ((n / 250) % 4 == 3) spr_x[10*i +: 10] = 10'($urandom_range(995, 1023));
                    else                    spr_x[10*i +: 10] = 10'($urandom_range(0, 60));
                    spr_y[10*i +: 10] = 10'($urandom_range(0, 60));
                end
                spr_en = NUM_SPR'($urandom_range(0, 15));
            end
            pix_valid = ($urandom_range(0, 9) < 8);
            if ((n / 250) % 4 == 3) DrawX = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(990, 1023))
                                                                        : 10'($urandom_range(0, 40));
            else DrawX = 10'($urandom_range(0, 90));
            DrawY = 10'($urandom_range(0, 90));
            frame_start = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NUM_SPR; i++) flash_req[i] = ($urandom_range(0, 99) < 2);
            if (n == 1500) Reset_n = 1'b0;
            if (n == 1503) Reset_n = 1'b1;
            tick();
        end
        pix_valid = 1'b0; frame_start = 1'b0; flash_req = '0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised, pipelined sprite compositor feeding the VGA output path. Replaces per-object hard-coded colour muxing with N generic sprite channels.
- Each channel does in-box detection and ROM address generation, then applies a colour-key test to its ROM data. Priority resolution is fixed, and a per-sprite blink ("hit flash") counter can hide a sprite on alternate frames.
- Also accumulates per-frame opaque-pixel collisions between sprites and reports them to game logic once per frame.

Parameters:
- NUM_SPR, 4, number of sprite channels; index 0 has highest priority.
- SPR_W_LOG2, 5, log2 of sprite width in pixels; also the row stride of the address.
- SPR_H_LOG2, 5, log2 of sprite height in pixels.
- ADDR_W, 19, width of each ROM read address.
- ROM_LAT, 1, clock cycles from rom_addr to valid rom_data (1..4).
- KEY_COLOR, 24'hFF0000, transparent colour key in {R,G,B} form.
- BG_COLOR, 24'hB7FE7B, background colour.
- FLASH_FRAMES, 6, number of frames a flash request lasts.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- pix_valid  in  1  DrawX/DrawY are inside the active area this cycle.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- spr_x  in  NUM_SPR*10  sprite top-left X; channel i occupies [10i+9:10i].
- spr_y  in  NUM_SPR*10  sprite top-left Y, packed the same way.
- spr_en  in  NUM_SPR  per-sprite enable; 0 means never drawn and never collides.
- flash_req  in  NUM_SPR  per-sprite one-cycle request to start blinking.
- rom_addr  out  NUM_SPR*ADDR_W  registered ROM read address per channel.
- rom_data  in  NUM_SPR*24  ROM pixel data {R,G,B}, ROM_LAT cycles after the matching address.
- VGA_R  out  8  red component.
- VGA_G  out  8  green component.
- VGA_B  out  8  blue component.
- pix_valid_out  out  1  pix_valid delayed to align with the VGA outputs.
- collide  out  NUM_SPR  bit i set if sprite i overlapped another sprite on an opaque pixel during the previous frame.
- collide_valid  out  1  one-cycle pulse when collide updates.

Behaviour:
- Reset (Reset_n=0, asynchronous) clears:
  - rom_addr, VGA_R/G/B, pix_valid_out, collide, collide_valid: all 0.
  - Pipeline valid and hit bits, flash counters, collision accumulator: all 0.
- Stage A, cycle 0 to registered at 1:
  - Box test, evaluated at 11 bits so there is no wraparound at 1023: hit_i = spr_en[i] & pix_valid & DrawX>=x_i & DrawX<x_i+2^SPR_W_LOG2 & DrawY>=y_i & DrawY<y_i+2^SPR_H_LOG2.
  - Address: rom_addr_i = ((DrawX-x_i) + ((DrawY-y_i)<<SPR_W_LOG2)) truncated to ADDR_W when hit_i, else 0.
  - hit_i and pix_valid are registered alongside the address.
- Delay: hit bits and valid are delayed a further ROM_LAT cycles so they align with rom_data.
- Stage B, registered output: opaque_i = hit_i & (rom_data_i != KEY_COLOR) & ~hidden_i.
  - Output colour is rom_data of the lowest-index opaque sprite, else BG_COLOR.
  - When aligned pix_valid=0, the output colour is 0.
- Total latency from DrawX/DrawY to VGA_*/pix_valid_out is ROM_LAT+2 cycles. The VGA timing generator must compensate for this.
- Flash counter per sprite (width ceil(log2(FLASH_FRAMES+1))):
  - flash_req[i] loads FLASH_FRAMES.
  - On frame_start, a nonzero counter decrements.
  - flash_req and frame_start in the same cycle: the load wins.
  - A new request while counting reloads the counter.
  - hidden_i = (cnt_i != 0) & cnt_i[0]. The sprite is therefore invisible on alternate frames and fully visible once the counter reaches 0.
  - Hidden sprites do not collide.
- Collision:
  - At stage B, if two or more opaque_i are set, OR those bits into acc.
  - On frame_start: collide <= acc | (current-cycle contribution); acc <= 0; collide_valid = 1 for exactly one cycle (registered, one cycle after frame_start).
  - Pixels still in flight in the pipeline when frame_start arrives belong to the new frame.
- Sprites partially off-screen: X+width may exceed 639; these pixels are never presented, so the sprite is clipped naturally.
- Reset mid-frame: all in-flight pixels are dropped. The first output after release is valid only ROM_LAT+2 cycles after pix_valid.

Test Plan:
- Reset held with pix_valid=1 -> VGA_*=0, collide=0, rom_addr=0. After release, with no sprite enabled, output is BG_COLOR B7/FE/7B exactly ROM_LAT+2 cycles after pix_valid.
- Sprite 0 at (100,50), DrawX=103, DrawY=52 -> rom_addr0=3+(2<<5)=67 one cycle later. ROM returns 24'h123456 -> VGA=12/34/56 at ROM_LAT+2. ROM returns FF0000 -> output is background.
- Sprites 0 and 2 both at (200,200), both opaque -> sprite 0 colour shown. At the next frame_start, collide=4'b0101 with a single collide_valid pulse. The following frame with no overlap gives collide=0.
- Sprite 1 at x=1000, DrawX=1010 -> hit with address 10. At x=1020, DrawX=3 -> no hit (no 10-bit wrap).
- flash_req[0], then 7 frame_starts -> counter 6,5,...,0. Sprite is hidden on the frames where the count is 5, 3, 1 and visible afterwards. flash_req coincident with frame_start loads 6.
- spr_en=0 on an overlapping opaque sprite -> it is not drawn and contributes no collide bit.
